// File: rtl/noc_flit_tx.sv
// Credit-based flit transmitter: local FIFO feeding a router input port, with packet tracking.
// Optional credit-overflow detection enabled by defining NOC_TX_CREDIT_CHECK_EN.
//
// state      | meaning
// PKT_IDLE   | no packet in flight; next sent flit is a head (or a single-flit packet)
// PKT_ACTIVE | head sent, tail not yet sent
module noc_flit_tx #(
    parameter int DATA_W     = 16,
    parameter int CREDITS    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_valid,
    input  logic [DATA_W-1:0]              src_data,
    input  logic                           src_last,
    output logic                           src_ready,
    output logic                           valid_o,
    output logic [DATA_W-1:0]              data_o,
    input  logic                           credit_i,
    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt_o,
    output logic                           busy_o,
    output logic [7:0]                     pkt_cnt_o,
    output logic                           err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS+1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        PKT_IDLE,
        PKT_ACTIVE
    } pkt_state_t;

    // FIFO storage: payload plus last bit in the MSB
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            send;
    logic [DATA_W:0] head;
    logic            head_last;

    logic [CW-1:0]   credit_cnt;
    pkt_state_t      state_q;
    pkt_state_t      state_d;
    logic            tail_sent;
    logic [7:0]      pkt_cnt;

    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign src_ready  = !fifo_full;
    assign push       = src_valid && !fifo_full;
    // Send uses only registered state, so a returning credit is usable next cycle
    assign send       = !fifo_empty && (credit_cnt != '0);
    assign head       = mem[rd_ptr];
    assign head_last  = head[DATA_W];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {src_last, src_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (send) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, send})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= send;
            if (send) begin
                data_o <= head[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_cnt <= CRED_MAX;
        end else if (send && !credit_i) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (credit_i && !send && (credit_cnt != CRED_MAX)) begin
            credit_cnt <= credit_cnt + 1'b1;
        end
    end

    assign credit_cnt_o = credit_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PKT_IDLE;
            pkt_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (tail_sent) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tail_sent = 1'b0;
        if (send) begin
            case (state_q)
                PKT_IDLE: begin
                    if (head_last) begin
                        tail_sent = 1'b1;
                    end else begin
                        state_d = PKT_ACTIVE;
                    end
                end
                PKT_ACTIVE: begin
                    if (head_last) begin
                        tail_sent = 1'b1;
                        state_d   = PKT_IDLE;
                    end
                end
                default: state_d = PKT_IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q == PKT_ACTIVE);
    assign pkt_cnt_o = pkt_cnt;

`ifdef NOC_TX_CREDIT_CHECK_EN
    logic err_q;

    // A credit beyond the router buffer depth means the two ends disagree; latch until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (credit_i && !send && (credit_cnt == CRED_MAX)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed self-checking bench for noc_flit_tx (DATA_W=16, CREDITS=4, FIFO_DEPTH=8).
module tb_noc_flit_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_last;
    logic        src_ready;
    logic        valid_o;
    logic [15:0] data_o;
    logic        credit_i;
    logic [2:0]  credit_cnt_o;
    logic        busy_o;
    logic [7:0]  pkt_cnt_o;
    logic        err_o;

    int n_chk = 0;
    int n_err = 0;

`ifdef NOC_TX_CREDIT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    noc_flit_tx #(.DATA_W(16), .CREDITS(4), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .credit_cnt_o (credit_cnt_o),
        .busy_o       (busy_o),
        .pkt_cnt_o    (pkt_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic l, input logic c);
        src_valid = v;
        src_data  = d;
        src_last  = l;
        credit_i  = c;
        @(posedge clk);
        #1;
    endtask

    int exh_v  [6] = '{0, 1, 1, 1, 1, 0};
    int exh_d  [6] = '{0, 1, 2, 3, 4, 4};
    int exh_cr [6] = '{4, 3, 2, 1, 0, 0};
    int exh_pk [6] = '{0, 1, 2, 3, 4, 4};

    initial begin
        rst = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("rst_valid", 32'(valid_o), 0);
        chk_eq("rst_data", 32'(data_o), 0);
        chk_eq("rst_credit", 32'(credit_cnt_o), 4);
        chk_eq("rst_busy", 32'(busy_o), 0);
        chk_eq("rst_pkt", 32'(pkt_cnt_o), 0);
        chk_eq("rst_err", 32'(err_o), 0);
        rst = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("idle_ready", 32'(src_ready), 1);
        chk_eq("idle_valid", 32'(valid_o), 0);
        chk_eq("idle_credit", 32'(credit_cnt_o), 4);

        // credit exhaustion: six single-flit packets, no credits returned
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 16'(k + 1), 1'b1, 1'b0);
            chk_eq($sformatf("exh_valid%0d", k), 32'(valid_o), 32'(exh_v[k]));
            chk_eq($sformatf("exh_data%0d", k), 32'(data_o), 32'(exh_d[k]));
            chk_eq($sformatf("exh_credit%0d", k), 32'(credit_cnt_o), 32'(exh_cr[k]));
            chk_eq($sformatf("exh_pkt%0d", k), 32'(pkt_cnt_o), 32'(exh_pk[k]));
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("stall_valid", 32'(valid_o), 0);
        chk_eq("stall_data", 32'(data_o), 32'h0004);
        chk_eq("stall_credit", 32'(credit_cnt_o), 0);
        chk_eq("stall_ready", 32'(src_ready), 1);

        // credit return: each pulse releases one held flit the cycle after
        for (int r = 0; r < 2; r++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            chk_eq($sformatf("ret_nosend%0d", r), 32'(valid_o), 0);
            chk_eq($sformatf("ret_credit_up%0d", r), 32'(credit_cnt_o), 1);
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
            chk_eq($sformatf("ret_valid%0d", r), 32'(valid_o), 1);
            chk_eq($sformatf("ret_data%0d", r), 32'(data_o), 32'(5 + r));
            chk_eq($sformatf("ret_credit_dn%0d", r), 32'(credit_cnt_o), 0);
            chk_eq($sformatf("ret_pkt%0d", r), 32'(pkt_cnt_o), 32'(5 + r));
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
            chk_eq($sformatf("ret_idle%0d", r), 32'(valid_o), 0);
        end

        // refill to four credits; reaching the maximum is not an overflow
        for (int r = 0; r < 4; r++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk_eq("refill_credit", 32'(credit_cnt_o), 4);
        chk_eq("refill_err", 32'(err_o), 0);

        // three-flit packet
        cyc(1'b1, 16'hA000, 1'b0, 1'b0);
        chk_eq("mf_v0", 32'(valid_o), 0);
        chk_eq("mf_busy0", 32'(busy_o), 0);
        cyc(1'b1, 16'hA001, 1'b0, 1'b0);
        chk_eq("mf_data1", 32'(valid_o ? data_o : 16'hFFFF), 32'hA000);
        chk_eq("mf_busy1", 32'(busy_o), 1);
        chk_eq("mf_pkt1", 32'(pkt_cnt_o), 6);
        cyc(1'b1, 16'hA002, 1'b1, 1'b0);
        chk_eq("mf_data2", 32'(valid_o ? data_o : 16'hFFFF), 32'hA001);
        chk_eq("mf_busy2", 32'(busy_o), 1);
        chk_eq("mf_pkt2", 32'(pkt_cnt_o), 6);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("mf_data3", 32'(valid_o ? data_o : 16'hFFFF), 32'hA002);
        chk_eq("mf_busy3", 32'(busy_o), 0);
        chk_eq("mf_pkt3", 32'(pkt_cnt_o), 7);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("mf_end_valid", 32'(valid_o), 0);
        chk_eq("mf_end_credit", 32'(credit_cnt_o), 1);

        // drain the last credit, then fill the FIFO
        cyc(1'b1, 16'hB000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("drain_data", 32'(valid_o ? data_o : 16'hFFFF), 32'hB000);
        chk_eq("drain_credit", 32'(credit_cnt_o), 0);
        chk_eq("drain_pkt", 32'(pkt_cnt_o), 8);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 16'hC000 + 16'(k), 1'b1, 1'b0);
            chk_eq($sformatf("fill_ready%0d", k), 32'(src_ready), (k < 7) ? 1 : 0);
        end
        chk_eq("fill_valid", 32'(valid_o), 0);
        cyc(1'b1, 16'hD000, 1'b1, 1'b0);
        chk_eq("full_hold_ready", 32'(src_ready), 0);
        cyc(1'b1, 16'hD000, 1'b1, 1'b1);
        chk_eq("full_credit_ready", 32'(src_ready), 0);
        chk_eq("full_credit_valid", 32'(valid_o), 0);
        chk_eq("full_credit_cnt", 32'(credit_cnt_o), 1);
        cyc(1'b1, 16'hD000, 1'b1, 1'b0);
        chk_eq("full_pop_data", 32'(valid_o ? data_o : 16'hFFFF), 32'hC000);
        chk_eq("full_pop_ready", 32'(src_ready), 1);
        chk_eq("full_pop_credit", 32'(credit_cnt_o), 0);
        for (int g = 0; g < 8; g++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            if (g == 0) begin
                chk_eq("flush_wait", 32'(valid_o), 0);
            end else begin
                chk_eq($sformatf("flush_data%0d", g), 32'(valid_o ? data_o : 16'hFFFF), 32'hC000 + 32'(g));
            end
            chk_eq($sformatf("flush_credit%0d", g), 32'(credit_cnt_o), 1);
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("flush_refused_push", 32'(valid_o), 0);
        chk_eq("flush_pkt", 32'(pkt_cnt_o), 16);
        chk_eq("flush_credit_end", 32'(credit_cnt_o), 1);

        // reset mid-packet clears packet state and credits
        cyc(1'b1, 16'hE000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("mid_busy", 32'(busy_o), 1);
        rst = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("mid_rst_busy", 32'(busy_o), 0);
        chk_eq("mid_rst_credit", 32'(credit_cnt_o), 4);
        chk_eq("mid_rst_pkt", 32'(pkt_cnt_o), 0);
        chk_eq("mid_rst_valid", 32'(valid_o), 0);
        rst = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // credit overflow with FIFO empty
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk_eq("ovf_credit", 32'(credit_cnt_o), 4);
        chk_eq("ovf_err", 32'(err_o), 32'(ERR_EXP));
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk_eq("ovf_err_sticky", 32'(err_o), 32'(ERR_EXP));
        chk_eq("ovf_credit_hold", 32'(credit_cnt_o), 4);
        chk_eq("ovf_valid", 32'(valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/noc_flit_tx.md
Name: noc_flit_tx

Overview:
- Credit-based flit transmitter that sits at the upstream end of a router input port, for example in a network interface or an upstream router output.
- Buffers flits from a local source in a small FIFO and drives valid_i/data_i into the router.
- Consumes the router's credit_o pulses and never sends a flit without a credit.
- Tracks packet boundaries so that busy status and a sent-packet count are available to control logic.

Parameters:
- DATA_W, 16: flit width; must match router data_i/data_o.
- CREDITS, 4: depth of the router input buffer; initial and maximum credit count.
- FIFO_DEPTH, 8: local flit FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- src_valid  input  1  local source presents a flit.
- src_data  input  DATA_W  local flit payload.
- src_last  input  1  flit is the packet tail; a single-flit packet has src_last=1.
- src_ready  output  1  FIFO can accept a flit; transfer occurs when src_valid and src_ready are both 1.
- valid_o  output  1  to router valid_i; one flit per cycle when high.
- data_o  output  DATA_W  to router data_i.
- credit_i  input  1  from router credit_o; one pulse per freed buffer slot.
- credit_cnt_o  output  $clog2(CREDITS+1)  current credits available.
- busy_o  output  1  a packet's head has been sent and its tail has not.
- pkt_cnt_o  output  8  packets completed (tails sent); wraps 255 to 0.
- err_o  output  1  sticky credit-overflow flag; see Optional Feature.

Behaviour:
- Reset is sampled at posedge while rst==0. Reset values:
  - valid_o=0, data_o=0, credit_cnt_o=CREDITS, busy_o=0, pkt_cnt_o=0, err_o=0.
  - FIFO empty; src_ready=1 from the first cycle after reset release.
- Reset mid-packet discards the FIFO contents and the in-flight packet state. No partial flush occurs.
- FIFO:
  - Width DATA_W+1 (payload plus the last bit).
  - src_ready = !full. It is based on registered occupancy only, so a push is refused when full even if a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty leaves occupancy unchanged.
  - No bypass: a flit written in cycle N can appear on valid_o no earlier than cycle N+1.
- Send condition: FIFO non-empty and credit_cnt>0.
  - When it holds, the head is popped and valid_o=1 and data_o=payload are registered for exactly one cycle. valid_o is a registered output.
  - When it does not hold, valid_o=0 and data_o holds its last value.
  - Back-to-back flits are sent every cycle while the condition holds, giving full throughput with CREDITS≥1 and immediate credit return.
- Credit counter, updated each cycle:
  - send and !credit_i: decrement.
  - credit_i and !send: increment.
  - both: unchanged.
  - Send is evaluated against the registered count, so a credit arriving at count 0 enables a send the following cycle, not the same cycle.
  - Increment at count==CREDITS saturates at CREDITS (overflow; see Optional Feature).
- Packet FSM (two states, advanced on each sent flit):
  - IDLE: a sent flit with last=0 goes to ACTIVE and busy_o=1. A sent flit with last=1 stays in IDLE and pkt_cnt_o increments.
  - ACTIVE: a sent flit with last=1 goes to IDLE, busy_o=0, and pkt_cnt_o increments. Otherwise the FSM stays in ACTIVE.
  - busy_o and pkt_cnt_o update in the same cycle that valid_o rises for the flit concerned.
- There is no packet-level credit reservation: a packet may stall mid-stream when credits run out.

Optional Feature:
- Macro: NOC_TX_CREDIT_CHECK_EN.
- Defined:
  - A credit_i pulse arriving while credit_cnt==CREDITS and no send occurs in that cycle sets err_o=1 on the next edge.
  - err_o stays 1 until reset. The count still saturates.
- Undefined:
  - err_o is tied to 0, the overflow logic is omitted, and saturation is still applied.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release -> valid_o=0, credit_cnt_o=4, src_ready=1, pkt_cnt_o=0, err_o=0.
- Credit exhaustion: push 6 single-flit packets 0x0001..0x0006 with no credit_i -> 4 flits on valid_o in 4 consecutive cycles starting 1 cycle after the first push; credit_cnt_o=0; 0x0005 and 0x0006 are held in the FIFO; pkt_cnt_o=4.
- Credit return: continuing from the previous scenario, pulse credit_i once -> 0x0005 sent in the following cycle, credit_cnt_o returns to 0; a second pulse sends 0x0006.
- Multi-flit packet: push 3 flits (0xA000, 0xA001, 0xA002 with last=1) with 4 credits -> busy_o=1 on the first two flits and 0 after the tail; pkt_cnt_o increments by exactly 1; credit_cnt_o=1.
- Full FIFO with simultaneous events: CREDITS=0 effective (credits drained), push 8 flits -> src_ready=0; then pulse credit_i while src_valid=1 -> one pop, no push that cycle, src_ready=1 on the next cycle.
- Overflow (macro defined): from reset, pulse credit_i with the FIFO empty -> credit_cnt_o stays 4 and err_o=1 one cycle later and stays 1. With the macro undefined, the same stimulus gives err_o=0.
